// File: rtl/commit_stage.sv
// commit_stage: in-order retirement end of the reservation/reorder buffer.
// Each cycle the oldest live entry (largest tag) and its successor (tag-1) are
// examined; up to two executed, non-speculative non-store entries retire.
// A store at the head is released through a req/ack handshake to the memory
// unit and frees its slot when acknowledged.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   entries_all       current buffer contents (BUF_SIZE entries)
//   flush             branch mispredict; suppresses retirement from IDLE
//   free_valid/index  slot k freed this cycle (combinational)
//   reg_we/waddr/wdata registered register-file write port pair; [1] is younger
//   st_req/addr/data  store release request, held until st_ack
//   st_ack            memory accepted the store
//   stores_retired    one-cycle pulse after a store retires
//   retired_count     running total of retired instructions (wraps)
//
// state   | meaning
// IDLE    | scanning heads, retiring non-stores or launching a store
// ST_WAIT | store request outstanding, waiting for st_ack

package commit_pkg;
   localparam int TAG_W = 5;

   typedef enum logic [1:0] {
      S_NOT_USED     = 2'd0,
      S_NOT_EXECUTED = 2'd1,
      S_EXECUTED     = 2'd2
   } e_state_t;

   typedef struct packed {
      e_state_t          e_state;
      logic [TAG_W-1:0]  tag;
      logic [5:0]        speculative_tag;
      logic              is_store;
      logic              is_branch;
      logic [4:0]        dest;
      logic [31:0]       result;
      logic [31:0]       vk;
   } entry_t;
endpackage

module commit_stage
   import commit_pkg::*;
#(
   parameter int BUF_SIZE     = 16,
   parameter int BUF_SIZE_LOG = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  entry_t                       entries_all [BUF_SIZE],
   input  logic                         flush,
   output logic [1:0]                   free_valid,
   output logic [1:0][BUF_SIZE_LOG-1:0] free_index,
   output logic [1:0]                   reg_we,
   output logic [1:0][4:0]              reg_waddr,
   output logic [1:0][31:0]             reg_wdata,
   output logic                         st_req,
   output logic [31:0]                  st_addr,
   output logic [31:0]                  st_data,
   input  logic                         st_ack,
   output logic                         stores_retired,
   output logic [31:0]                  retired_count
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [0:0]              state_q, state_d;
   logic                    h0_found, h1_found;
   logic [BUF_SIZE_LOG-1:0] h0_idx, h1_idx;
   logic [TAG_W-1:0]        h0_tag;
   entry_t                  h0, h1;
   logic                    ret0, ret1, st_start, st_done;
   logic                    we0_d, we1_d;

   logic [1:0]              reg_we_q;
   logic [1:0][4:0]         reg_waddr_q;
   logic [1:0][31:0]        reg_wdata_q;
   logic                    st_req_q;
   logic [31:0]             st_addr_q, st_data_q;
   logic [BUF_SIZE_LOG-1:0] st_idx_q;
   logic                    stores_retired_q;
   logic [31:0]             retired_count_q;

   function automatic logic eligible(entry_t e);
      return (e.e_state == S_EXECUTED) && (e.speculative_tag == '0);
   endfunction

   // Live tags never wrap (dispatch stalls first), so a plain unsigned max works.
   always_comb begin
      h0_found = 1'b0;
      h0_idx   = '0;
      h0_tag   = '0;
      for (int i = 0; i < BUF_SIZE; i++) begin
         if (entries_all[i].e_state != S_NOT_USED &&
             (!h0_found || entries_all[i].tag > h0_tag)) begin
            h0_found = 1'b1;
            h0_idx   = BUF_SIZE_LOG'(i);
            h0_tag   = entries_all[i].tag;
         end
      end
      h1_found = 1'b0;
      h1_idx   = '0;
      for (int i = 0; i < BUF_SIZE; i++) begin
         if (h0_found && entries_all[i].e_state != S_NOT_USED &&
             entries_all[i].tag == h0_tag - TAG_W'(1)) begin
            h1_found = 1'b1;
            h1_idx   = BUF_SIZE_LOG'(i);
         end
      end
   end

   assign h0 = entries_all[h0_idx];
   assign h1 = entries_all[h1_idx];

   always_comb begin
      state_d  = state_q;
      ret0     = 1'b0;
      ret1     = 1'b0;
      st_start = 1'b0;
      st_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!flush && h0_found && eligible(h0)) begin
               if (!h0.is_store) begin
                  ret0 = 1'b1;
                  // a store in slot 1 waits: at most one store per cycle, and only from slot 0
                  ret1 = h1_found && eligible(h1) && !h1.is_store;
               end else begin
                  st_start = 1'b1;
                  state_d  = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // flush deliberately ignored: the store is already non-speculative
            if (st_ack) begin
               st_done = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign we0_d = ret0 && !h0.is_branch && (h0.dest != 5'd0);
   assign we1_d = ret1 && !h1.is_branch && (h1.dest != 5'd0);

   assign free_valid    = {ret1, ret0 | st_done};
   assign free_index[0] = st_done ? st_idx_q : h0_idx;
   assign free_index[1] = h1_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         reg_we_q         <= '0;
         reg_waddr_q      <= '0;
         reg_wdata_q      <= '0;
         st_req_q         <= 1'b0;
         st_addr_q        <= '0;
         st_data_q        <= '0;
         st_idx_q         <= '0;
         stores_retired_q <= 1'b0;
         retired_count_q  <= '0;
      end else begin
         state_q  <= state_d;
         reg_we_q <= {we1_d, we0_d};
         if (we0_d) begin
            reg_waddr_q[0] <= h0.dest;
            reg_wdata_q[0] <= h0.result;
         end
         if (we1_d) begin
            reg_waddr_q[1] <= h1.dest;
            reg_wdata_q[1] <= h1.result;
         end
         if (st_start) begin
            st_req_q  <= 1'b1;
            st_addr_q <= h0.result;
            st_data_q <= h0.vk;
            st_idx_q  <= h0_idx;
         end else if (st_done) begin
            st_req_q <= 1'b0;
         end
         stores_retired_q <= st_done;
         retired_count_q  <= retired_count_q + 32'(ret0) + 32'(ret1) + 32'(st_done);
      end
   end

   assign reg_we         = reg_we_q;
   assign reg_waddr      = reg_waddr_q;
   assign reg_wdata      = reg_wdata_q;
   assign st_req         = st_req_q;
   assign st_addr        = st_addr_q;
   assign st_data        = st_data_q;
   assign stores_retired = stores_retired_q;
   assign retired_count  = retired_count_q;

endmodule

// File: tb/tb_commit_stage.sv
module tb_commit_stage;
   import commit_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   entry_t            ent [16];
   logic              flush;
   logic [1:0]        free_valid;
   logic [1:0][3:0]   free_index;
   logic [1:0]        reg_we;
   logic [1:0][4:0]   reg_waddr;
   logic [1:0][31:0]  reg_wdata;
   logic              st_req;
   logic [31:0]       st_addr, st_data;
   logic              st_ack;
   logic              stores_retired;
   logic [31:0]       retired_count;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_cnt;

   commit_stage #(.BUF_SIZE(16), .BUF_SIZE_LOG(4)) dut (
      .clk(clk), .rst_n(rst_n), .entries_all(ent), .flush(flush),
      .free_valid(free_valid), .free_index(free_index),
      .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
      .stores_retired(stores_retired), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic entry_t mk(input e_state_t st, input logic [4:0] tag, input logic [5:0] sp,
                                 input logic is_st, input logic is_br, input logic [4:0] d,
                                 input logic [31:0] r, input logic [31:0] vk);
      entry_t e;
      e.e_state = st; e.tag = tag; e.speculative_tag = sp; e.is_store = is_st;
      e.is_branch = is_br; e.dest = d; e.result = r; e.vk = vk;
      return e;
   endfunction

   task automatic clear_ents();
      for (int i = 0; i < 16; i++) ent[i] = '0;
   endtask

   typedef struct {
      int         ia;
      entry_t     a;
      int         ib;
      entry_t     b;
      logic       fl;
      logic [1:0] fv;
      logic [3:0] fi0, fi1;
      logic [1:0] we;
      logic [4:0] wa0, wa1;
      logic [31:0] wd0, wd1;
      int         inc;
   } vec_t;

   vec_t v [11];

   initial begin
      entry_t ex15, ex14;
      rst_n = 1'b0; flush = 1'b0; st_ack = 1'b0;
      clear_ents();
      exp_cnt = 0;

      // ----- table -----
      ex15 = mk(S_EXECUTED, 5'd15, 6'd0, 1'b0, 1'b0, 5'd3, 32'h11, 32'h0);
      ex14 = mk(S_EXECUTED, 5'd14, 6'd0, 1'b0, 1'b0, 5'd4, 32'h22, 32'h0);
      v[0]  = '{0, ex15, 1, ex14, 1'b0, 2'b11, 4'd0, 4'd1, 2'b11, 5'd3, 5'd4, 32'h11, 32'h22, 2};
      v[1]  = '{0, ex15, 1, ex14, 1'b1, 2'b00, 4'd0, 4'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0};
      v[2]  = '{5, mk(S_NOT_EXECUTED, 5'd15, 6'd0, 1'b0, 1'b0, 5'd3, 32'h11, 32'h0),
                2, mk(S_EXECUTED, 5'd14, 6'd0, 1'b0, 1'b0, 5'd4, 32'h22, 32'h0),
                1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0};
      v[3]  = '{0, mk(S_EXECUTED, 5'd15, 6'b000001, 1'b0, 1'b0, 5'd3, 32'h11, 32'h0),
                1, ex14, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0};
      v[4]  = '{7, mk(S_EXECUTED, 5'd9, 6'd0, 1'b0, 1'b0, 5'd0, 32'h55, 32'h0),
                3, mk(S_EXECUTED, 5'd8, 6'd0, 1'b0, 1'b0, 5'd6, 32'h66, 32'h0),
                1'b0, 2'b11, 4'd7, 4'd3, 2'b10, 5'd0, 5'd6, 32'h0, 32'h66, 2};
      v[5]  = '{2, mk(S_EXECUTED, 5'd7, 6'd0, 1'b0, 1'b1, 5'd8, 32'h99, 32'h0),
                3, mk(S_NOT_EXECUTED, 5'd6, 6'd0, 1'b0, 1'b0, 5'd9, 32'h1, 32'h0),
                1'b0, 2'b01, 4'd2, 4'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1};
      v[6]  = '{0, mk(S_EXECUTED, 5'd20, 6'd0, 1'b0, 1'b0, 5'd5, 32'h5, 32'h0),
                1, mk(S_EXECUTED, 5'd18, 6'd0, 1'b0, 1'b0, 5'd7, 32'h7, 32'h0),
                1'b0, 2'b01, 4'd0, 4'd0, 2'b01, 5'd5, 5'd0, 32'h5, 32'h0, 1};
      v[7]  = '{10, mk(S_EXECUTED, 5'd3, 6'd0, 1'b0, 1'b0, 5'd9, 32'hAA, 32'h0),
                11, mk(S_EXECUTED, 5'd2, 6'd0, 1'b0, 1'b0, 5'd9, 32'hBB, 32'h0),
                1'b0, 2'b11, 4'd10, 4'd11, 2'b11, 5'd9, 5'd9, 32'hAA, 32'hBB, 2};
      v[8]  = '{0, mk(S_EXECUTED, 5'd10, 6'd0, 1'b0, 1'b0, 5'd2, 32'h2, 32'h0),
                1, mk(S_EXECUTED, 5'd9, 6'd0, 1'b1, 1'b0, 5'd0, 32'h200, 32'h5),
                1'b0, 2'b01, 4'd0, 4'd0, 2'b01, 5'd2, 5'd0, 32'h2, 32'h0, 1};
      v[9]  = '{-1, ex15, -1, ex14, 1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0};
      v[10] = '{4, mk(S_EXECUTED, 5'd6, 6'd0, 1'b0, 1'b0, 5'd1, 32'h10, 32'h0),
                12, mk(S_EXECUTED, 5'd5, 6'b000010, 1'b0, 1'b0, 5'd2, 32'h20, 32'h0),
                1'b0, 2'b01, 4'd4, 4'd0, 2'b01, 5'd1, 5'd0, 32'h10, 32'h0, 1};

      // ----- reset values -----
      #12;
      chk("rst_reg_we", 32'(reg_we), 32'h0);
      chk("rst_st_req", 32'(st_req), 32'h0);
      chk("rst_st_addr", st_addr, 32'h0);
      chk("rst_stores_retired", 32'(stores_retired), 32'h0);
      chk("rst_retired_count", retired_count, 32'h0);
      chk("rst_free_valid", 32'(free_valid), 32'h0);
      @(negedge clk); rst_n = 1'b1;

      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         clear_ents();
         if (v[k].ia >= 0) ent[v[k].ia] = v[k].a;
         if (v[k].ib >= 0) ent[v[k].ib] = v[k].b;
         flush = v[k].fl;
         #1;
         chk($sformatf("v%0d_free_valid", k), 32'(free_valid), 32'(v[k].fv));
         if (v[k].fv[0]) chk($sformatf("v%0d_free_index0", k), 32'(free_index[0]), 32'(v[k].fi0));
         if (v[k].fv[1]) chk($sformatf("v%0d_free_index1", k), 32'(free_index[1]), 32'(v[k].fi1));
         @(posedge clk); #1;
         exp_cnt = exp_cnt + 32'(v[k].inc);
         chk($sformatf("v%0d_reg_we", k), 32'(reg_we), 32'(v[k].we));
         if (v[k].we[0]) begin
            chk($sformatf("v%0d_waddr0", k), 32'(reg_waddr[0]), 32'(v[k].wa0));
            chk($sformatf("v%0d_wdata0", k), reg_wdata[0], v[k].wd0);
         end
         if (v[k].we[1]) begin
            chk($sformatf("v%0d_waddr1", k), 32'(reg_waddr[1]), 32'(v[k].wa1));
            chk($sformatf("v%0d_wdata1", k), reg_wdata[1], v[k].wd1);
         end
         chk($sformatf("v%0d_count", k), retired_count, exp_cnt);
         chk($sformatf("v%0d_st_req", k), 32'(st_req), 32'h0);
         clear_ents();
         flush = 1'b0;
      end

      // ----- head becomes executed later -----
      @(negedge clk);
      ent[0] = mk(S_NOT_EXECUTED, 5'd15, 6'd0, 1'b0, 1'b0, 5'd3, 32'h31, 32'h0);
      ent[1] = mk(S_EXECUTED, 5'd14, 6'd0, 1'b0, 1'b0, 5'd4, 32'h41, 32'h0);
      #1 chk("inorder_wait_fv", 32'(free_valid), 32'h0);
      @(posedge clk); #1 chk("inorder_wait_cnt", retired_count, exp_cnt);
      @(negedge clk); ent[0].e_state = S_EXECUTED;
      #1 chk("inorder_go_fv", 32'(free_valid), 32'h3);
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 2;
      chk("inorder_go_we", 32'(reg_we), 32'h3);
      chk("inorder_go_wd0", reg_wdata[0], 32'h31);
      chk("inorder_go_cnt", retired_count, exp_cnt);
      clear_ents();

      // ----- speculative tag clears -----
      @(negedge clk);
      ent[0] = mk(S_EXECUTED, 5'd15, 6'b000001, 1'b0, 1'b0, 5'd3, 32'h57, 32'h0);
      #1 chk("spec_hold_fv", 32'(free_valid), 32'h0);
      @(posedge clk); #1 chk("spec_hold_we", 32'(reg_we), 32'h0);
      ent[0].speculative_tag = 6'd0;
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 1;
      chk("spec_go_we", 32'(reg_we), 32'h1);
      chk("spec_go_wd0", reg_wdata[0], 32'h57);
      chk("spec_go_cnt", retired_count, exp_cnt);
      clear_ents();

      // ----- st_ack in IDLE ignored -----
      @(negedge clk); st_ack = 1'b1;
      #1 chk("idle_ack_fv", 32'(free_valid), 32'h0);
      @(posedge clk); #1 st_ack = 1'b0;
      chk("idle_ack_cnt", retired_count, exp_cnt);
      chk("idle_ack_sr", 32'(stores_retired), 32'h0);

      // ----- store handshake, held 3 cycles, flush ignored while waiting -----
      @(negedge clk);
      ent[4] = mk(S_EXECUTED, 5'd12, 6'd0, 1'b1, 1'b0, 5'd0, 32'h100, 32'hAB);
      #1 chk("st_launch_fv", 32'(free_valid), 32'h0);
      @(posedge clk); #1;
      chk("st_req_up", 32'(st_req), 32'h1);
      chk("st_addr", st_addr, 32'h100);
      chk("st_data", st_data, 32'hAB);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); flush = (k == 1);
         #1 chk($sformatf("st_wait%0d_fv", k), 32'(free_valid), 32'h0);
         @(posedge clk); #1;
         chk($sformatf("st_wait%0d_req", k), 32'(st_req), 32'h1);
         chk($sformatf("st_wait%0d_addr", k), st_addr, 32'h100);
         chk($sformatf("st_wait%0d_cnt", k), retired_count, exp_cnt);
      end
      @(negedge clk); flush = 1'b0; st_ack = 1'b1;
      #1;
      chk("st_ack_fv", 32'(free_valid), 32'h1);
      chk("st_ack_fi0", 32'(free_index[0]), 32'd4);
      @(posedge clk); #1;
      st_ack = 1'b0;
      clear_ents();
      exp_cnt = exp_cnt + 1;
      chk("st_done_req", 32'(st_req), 32'h0);
      chk("st_done_sr", 32'(stores_retired), 32'h1);
      chk("st_done_cnt", retired_count, exp_cnt);
      @(posedge clk); #1;
      chk("st_sr_pulse_end", 32'(stores_retired), 32'h0);
      chk("st_no_rereq", 32'(st_req), 32'h0);

      // ----- non-store then store in slot 1; ack when req first rises -----
      @(negedge clk);
      ent[0] = mk(S_EXECUTED, 5'd10, 6'd0, 1'b0, 1'b0, 5'd2, 32'h2, 32'h0);
      ent[1] = mk(S_EXECUTED, 5'd9, 6'd0, 1'b1, 1'b0, 5'd0, 32'h200, 32'h5);
      #1 chk("mix_fv", 32'(free_valid), 32'h1);
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 1;
      ent[0] = '0;
      chk("mix_req_not_yet", 32'(st_req), 32'h0);
      chk("mix_cnt", retired_count, exp_cnt);
      @(posedge clk); #1;
      chk("mix_req", 32'(st_req), 32'h1);
      chk("mix_addr", st_addr, 32'h200);
      chk("mix_data", st_data, 32'h5);
      st_ack = 1'b1;
      #1;
      chk("mix_ack_fv", 32'(free_valid), 32'h1);
      chk("mix_ack_fi0", 32'(free_index[0]), 32'd1);
      @(posedge clk); #1;
      st_ack = 1'b0;
      clear_ents();
      exp_cnt = exp_cnt + 1;
      chk("mix_sr", 32'(stores_retired), 32'h1);
      chk("mix_done_cnt", retired_count, exp_cnt);

      // ----- reset while in ST_WAIT -----
      @(negedge clk);
      ent[6] = mk(S_EXECUTED, 5'd3, 6'd0, 1'b1, 1'b0, 5'd0, 32'h300, 32'h77);
      @(posedge clk); #1 chk("rw_req_up", 32'(st_req), 32'h1);
      @(negedge clk); rst_n = 1'b0;
      #1;
      exp_cnt = 0;
      chk("rw_req_cleared", 32'(st_req), 32'h0);
      chk("rw_cnt_cleared", retired_count, exp_cnt);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rw_rereq", 32'(st_req), 32'h1);
      chk("rw_rereq_addr", st_addr, 32'h300);
      chk("rw_rereq_data", st_data, 32'h77);
      st_ack = 1'b1;
      @(posedge clk); #1;
      st_ack = 1'b0;
      clear_ents();
      exp_cnt = exp_cnt + 1;
      chk("rw_done_req", 32'(st_req), 32'h0);
      chk("rw_done_cnt", retired_count, exp_cnt);

      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/commit_stage.md
Name: commit_stage

Overview:
- In-order retirement stage: the consumer end of the reservation/reorder buffer that dispatch fills.
- Each cycle it scans all buffer entries and finds the oldest live entry, which has the largest tag. It retires up to 2 executed, non-speculative entries in program order.
- Retiring an entry writes the register file, frees the buffer slot and counts the retirement.
- Stores are released to the memory unit through a req/ack handshake before the entry is freed.

Parameters:
BUF_SIZE, 16, number of buffer entries
BUF_SIZE_LOG, 4, log2(BUF_SIZE); entry tag width is BUF_SIZE_LOG+1

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
entries_all  in  entry[BUF_SIZE]  current buffer contents
flush  in  1  branch mispredict this cycle; suppresses retirement
free_valid  out  1[2]  slot k freed this cycle (combinational); the buffer owner sets e_state=S_NOT_USED at the edge
free_index  out  BUF_SIZE_LOG[2]  index of the freed slot
reg_we  out  1[2]  registered register-file write enable
reg_waddr  out  5[2]  registered write address (entry Dest)
reg_wdata  out  32[2]  registered write data (entry result)
st_req  out  1  store release request
st_addr  out  32  store address (entry result)
st_data  out  32  store data (entry Vk)
st_ack  in  1  memory accepted the store
stores_retired  out  1  registered pulse: one store retired last cycle
retired_count  out  32  total instructions retired

Behaviour:
- Reset values:
  - reg_we=0, reg_waddr=0, reg_wdata=0
  - st_req=0, st_addr=0, st_data=0
  - stores_retired=0, retired_count=0
  - FSM=IDLE
  - Reset is asynchronous; the FSM and all registers clear immediately even mid-store.
- Head search:
  - head0 = the used entry (e_state != S_NOT_USED) with the maximum tag.
  - head1 = the used entry whose tag equals head0.tag-1.
  - Dispatch's tag-flood stall guarantees no wrap among live entries, so plain unsigned comparison is used.
  - If the buffer is empty, nothing retires.
- Commit eligibility of an entry:
  - e_state==S_EXECUTED and speculative_tag==0.
  - head1 is considered only if head0 retires in the same cycle.
- Register write rules:
  - A non-store entry with Dest!=0 writes the register file; Dest==0 means no write.
  - Branch and store entries retire without a register write.
- FSM IDLE:
  - If flush is high, nothing retires.
  - Else if head0 is eligible and not a store, retire head0. Then retire head1 too if it is eligible and not a store. At most one store per cycle; a store in slot 1 waits for the next cycle.
  - Else if head0 is an eligible store: assert st_req, latch st_addr and st_data, record the head0 index, and go to ST_WAIT. No retirement that cycle.
- FSM ST_WAIT:
  - st_req is held high with stable addr/data until st_ack.
  - Nothing else retires while waiting.
  - flush is ignored: the store is already non-speculative.
  - On st_ack: free the recorded index that cycle, drop st_req, set stores_retired=1 on the next cycle, increment retired_count by 1, return to IDLE.
  - If st_ack arrives in the same cycle st_req first rises, it is still honoured.
  - st_ack while in IDLE is ignored.
- Retirement effects, in the cycle of retirement:
  - free_valid and free_index are combinational.
  - reg_we, reg_waddr and reg_wdata appear the next cycle (1-cycle latency).
  - retired_count advances by 0, 1 or 2 and wraps modulo 2^32.
- Free slots:
  - If only slot 0 retires, free_valid[1]=0.
  - The two free_index values are always distinct when both are valid.
- Writes:
  - If both slots write the same register, slot 1 is the younger and is authoritative.
  - The register file must apply reg_we[1] last.

Test Plan:
- Reset with entries A(tag 15, executed, Dest 3, result 0x11) and B(tag 14, executed, Dest 4, result 0x22) -> free_valid={1,1}; the next cycle reg_we={1,1} with x3=0x11 and x4=0x22; retired_count=2.
- Head tag 15 in state S_NOT_EXECUTED, tag 14 executed -> nothing retires (in-order); retirement occurs only once tag 15 becomes executed.
- Head executed but speculative_tag=6'b000001 -> no retire; when the tag clears to 0 -> retires the next cycle.
- Head executed store (addr 0x100, data 0xAB): st_req=1 with st_addr=0x100 and st_data=0xAB, held 3 cycles; then st_ack -> slot freed, stores_retired pulses once, retired_count+1.
- Entry 0 non-store, entry 1 store, both executed -> only entry 0 retires this cycle; the store starts its handshake the next cycle.
- rst_n asserted low while in ST_WAIT -> st_req=0 immediately and FSM=IDLE; after release, a pending store is re-requested.
